// File: rtl/btn_event_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btn_arb_pkg
//  Description : Shared constants and helper functions for the button event
//                arbiter. It provides the default channel count and FIFO
//                depth, a constant-evaluable clog2, and the derivation of the
//                event id width.
//  Revision    : 1.0 - initial release
// ============================================================================
package btn_arb_pkg;

    localparam int C_N_BTN_DEFAULT = 4;
    localparam int C_DEPTH_DEFAULT = 4;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // An event id must be able to name every button, and it is at least one
    // bit wide.
    function automatic int id_width(input int n_btn);
        return (n_btn < 2) ? 1 : clog2(n_btn);
    endfunction

endpackage : btn_arb_pkg
`default_nettype wire

// File: rtl/btn_event_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter_if
//  Description : Valid/ready event stream from the arbiter to its consumer.
//                Ports:
//                  evt_valid - the head event is present
//                  evt_id    - button index of the head event
//                  evt_ready - the consumer accepts the head event
//                Modports: master (arbiter side), slave (consumer side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface btn_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic [ID_W-1:0] evt_id;
    logic            evt_ready;

    modport master (
        output evt_valid,
        output evt_id,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_id,
        output evt_ready
    );
endinterface : btn_event_arbiter_if
`default_nettype wire

// File: rtl/btn_event_arbiter_evt_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : evt_fifo
//  Description : Synchronous show-ahead FIFO. The head entry is always present
//                on pop_data. A push while full is ignored, and so is a pop
//                while empty.
//                Ports: clk_in, rst (sync, active high), push/push_data,
//                       pop/pop_data, full, empty, count.
//  Revision    : 1.0 - initial release
// ============================================================================
module evt_fifo
    import btn_arb_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4          // power of 2, >= 2
) (
    input  wire logic                    clk_in,
    input  wire logic                    rst,
    input  wire logic                    push,
    input  wire logic [WIDTH-1:0]        push_data,
    input  wire logic                    pop,
    output logic      [WIDTH-1:0]        pop_data,
    output logic                         full,
    output logic                         empty,
    output logic      [clog2(DEPTH):0]   count
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign pop_data  = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    // Because DEPTH is a power of 2, the pointers wrap naturally.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : evt_fifo
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : btn_event_arbiter
//  Description : Captures one-cycle button pulses into pending flags. The
//                flags are arbitrated into a single ordered event FIFO, and
//                the events are presented on a valid/ready stream.
//                Ports:
//                  clk_in, rst   - clock, synchronous active-high reset
//                  pulse_in      - one-shot pulses, bit i = button i
//                  evt           - event stream (master modport)
//                  pend          - captured but not yet queued pulses
//                  fifo_count    - number of queued events
//                  overflow      - sticky, a pulse was lost
//                  ovf_clr       - clears overflow (a set in the same cycle wins)
//                Build option: BTN_ARB_FIXED_PRIO_EN selects fixed priority
//                (the lowest index wins) instead of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_event_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_BTN = C_N_BTN_DEFAULT,   // 2..8
    parameter int DEPTH = C_DEPTH_DEFAULT    // power of 2, >= 2
) (
    input  wire logic                     clk_in,
    input  wire logic                     rst,
    input  wire logic [N_BTN-1:0]         pulse_in,
    btn_event_arbiter_if.master           evt,
    output logic      [N_BTN-1:0]         pend,
    output logic      [clog2(DEPTH):0]    fifo_count,
    output logic                          overflow,
    input  wire logic                     ovf_clr
);

    localparam int ID_W = id_width(N_BTN);

    logic [N_BTN-1:0] r_pend;
    logic             r_overflow;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [ID_W-1:0]  w_head_id;
    logic             w_pop;
    logic             w_req_vld;
    logic [ID_W-1:0]  w_grant_idx;
    logic             w_push;
    logic [N_BTN-1:0] w_grant_oh;
    logic             w_ovf_set;

`ifdef BTN_ARB_FIXED_PRIO_EN
    // Fixed priority: the lowest pending index wins. The scan runs downward,
    // so the last hit is the lowest index.
    always_comb begin
        w_req_vld   = 1'b0;
        w_grant_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_req_vld   = 1'b1;
                w_grant_idx = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0] r_rr_ptr;

    // Round-robin: find the first pending bit at or after r_rr_ptr. The scan
    // covers offsets from highest to lowest, so the smallest offset wins.
    always_comb begin
        int v_idx;
        v_idx       = 0;
        w_req_vld   = 1'b0;
        w_grant_idx = '0;
        for (int k = N_BTN - 1; k >= 0; k--) begin
            v_idx = (int'(r_rr_ptr) + k) % N_BTN;
            if (r_pend[ID_W'(v_idx)]) begin
                w_req_vld   = 1'b1;
                w_grant_idx = ID_W'(v_idx);
            end
        end
    end

    // The pointer moves past the winner only when a grant actually happens.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_grant_idx == ID_W'(N_BTN - 1)) ? '0 : w_grant_idx + 1'b1;
        end
    end
`endif

    // A full FIFO blocks the grant even if a pop frees an entry this cycle.
    assign w_push = w_req_vld & ~w_fifo_full;
    assign w_pop  = ~w_fifo_empty & evt.evt_ready;

    always_comb begin
        w_grant_oh = '0;
        if (w_push) begin
            w_grant_oh[w_grant_idx] = 1'b1;
        end
    end

    // A pulse on a still-pending channel that is not being granted is lost.
    assign w_ovf_set = |(pulse_in & r_pend & ~w_grant_oh);

    // If a new pulse arrives on the channel being granted, the OR re-sets the
    // flag, so the fresh pulse is retained while the old one is queued.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_pend     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pend     <= (r_pend & ~w_grant_oh) | pulse_in;
            r_overflow <= w_ovf_set | (r_overflow & ~ovf_clr);
        end
    end

    evt_fifo #(
        .WIDTH (ID_W),
        .DEPTH (DEPTH)
    ) u_evt_fifo (
        .clk_in    (clk_in),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_grant_idx),
        .pop       (w_pop),
        .pop_data  (w_head_id),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (fifo_count)
    );

    assign evt.evt_valid = ~w_fifo_empty;
    assign evt.evt_id    = w_head_id;
    assign pend          = r_pend;
    assign overflow      = r_overflow;

endmodule : btn_event_arbiter
`default_nettype wire

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
- Collects one-cycle pulses from N debounced one-shot button channels.
- Arbitrates the pending pulses round-robin into a single ordered event stream, buffered in a small FIFO.
- Presents events with a valid/ready handshake to the downstream sequence detector / control FSM.
- Sits between the per-button one-shot debouncers and the lab control logic, so simultaneous presses are serialised, never merged or dropped silently.

Parameters:
- N_BTN, 4: number of pulse input channels (2..8).
- DEPTH, 4: event FIFO depth in entries; power of 2, at least 2.
- ID_W, clog2(N_BTN): event id width. Derived localparam, not overridable.

Ports:
- clk_in, input, 1: system clock; all logic is on the rising edge.
- rst, input, 1: synchronous, active-high reset, sampled on the clk_in rising edge.
- pulse_in, input, N_BTN: one-cycle pulses from the one-shot debouncers; bit i is button i.
- evt_valid, output, 1: FIFO head holds an event.
- evt_id, output, ID_W: button index of the head event. Valid only while evt_valid is high.
- evt_ready, input, 1: consumer accepts the head event this cycle.
- pend, output, N_BTN: pending flags, i.e. pulses captured but not yet queued.
- fifo_count, output, clog2(DEPTH)+1: number of queued events.
- overflow, output, 1: sticky flag; a pulse was lost.
- ovf_clr, input, 1: clears overflow.

Behaviour:
- Reset: when rst is high at an edge, the following are cleared, overriding all other activity that cycle, including mid-transfer:
  - pend = 0, FIFO empty, evt_valid = 0, evt_id = 0, fifo_count = 0, overflow = 0, rr_ptr = 0.
- Capture:
  - pend[i] is set at the edge where pulse_in[i] = 1.
  - If pend[i] is being granted at that same edge, pend[i] stays 1: the new pulse is retained and the old one is queued.
- Grant:
  - Each cycle, if pend != 0 and fifo_count < DEPTH, exactly one bit is granted.
  - The granted bit is the first set bit at or after rr_ptr, searching upward with wrap at N_BTN-1 -> 0.
  - On a grant at an edge:
    - the grant index is written to the FIFO tail;
    - pend[g] is cleared, unless the retain rule above applies;
    - rr_ptr becomes (g+1) mod N_BTN.
  - With no grant, rr_ptr holds.
- Full FIFO: when fifo_count = DEPTH, no grant is made, even if a pop occurs in the same cycle. pend holds.
- Latency:
  - A pulse sampled at edge k sets pend after edge k.
  - With no contention, it is queued at edge k+1.
  - evt_valid is high after edge k+1, i.e. 2 cycles total.
- FIFO (show-ahead):
  - evt_valid = (fifo_count != 0); evt_id = head entry.
  - A pop happens at an edge with evt_valid & evt_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - evt_ready while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Overflow:
  - overflow is set at an edge where pulse_in[i] = 1, pend[i] = 1, and bit i is not granted that edge. The pulse is lost.
  - ovf_clr clears overflow. If a set and a clear occur in the same cycle, the set wins.
- Ordering: events for the same button are never reordered; across buttons the order is arbitration order.

Optional Feature:
- Macro: BTN_ARB_FIXED_PRIO_EN.
- When defined:
  - Fixed priority replaces round-robin; the lowest set index always wins.
  - rr_ptr is removed.
  - Everything else is unchanged.
- When undefined: round-robin arbitration as above.

Decomposition:
- Shared package btn_arb_pkg holds:
  - clog2 function;
  - default N_BTN and DEPTH constants;
  - the ID_W derivation.
- One sub-module, evt_fifo: a parameterised synchronous show-ahead FIFO with push, pop, full, empty and count.
- Arbitration, pend and overflow logic stay in the top module.

Test Plan:
- Reset then idle: drive pulse_in = 4'b0010 for 1 cycle -> pend = 0010 after 1 edge; evt_valid = 1, evt_id = 1 after the 2nd edge; with evt_ready = 1 for one cycle, fifo_count returns to 0.
- Simultaneous pulses: pulse_in = 4'b1111 for 1 cycle with evt_ready = 0 -> ids queued in order 0, 1, 2, 3 over 4 cycles, fifo_count = 4, pend = 0.
- Full FIFO: as the previous scenario, then pulse_in = 4'b0001 -> pend[0] = 1 and stays 1; a single pop frees an entry and id 0 is queued on the following edge.
- Overflow: with FIFO full and pend[2] = 1, pulse_in = 4'b0100 -> overflow = 1. Assert ovf_clr for 1 cycle with no pulse -> overflow = 0.
- Fairness: button 0 pulses every cycle and button 3 pulses once, with evt_ready = 1 -> id 3 appears within 4 events. Under BTN_ARB_FIXED_PRIO_EN, id 3 is starved while pend[0] stays set.
- Reset mid-operation: with FIFO holding 3 events and pend = 1010, assert rst for 1 cycle -> all outputs 0 at the next edge, and a subsequent pulse on button 2 yields evt_id = 2 after 2 cycles.
